// File: rtl/ray_inv_dir_setup.sv
// Per-ray setup: origin pass-through plus signed Q18.18 reciprocal of each direction
// axis, computed by three lock-stepped bit-serial restoring dividers under one FSM.
module ray_inv_dir_setup #(
   parameter int DIR_W    = 28,
   parameter int DIR_FRAC = 14,
   parameter int OUT_W    = 36,
   parameter int OUT_FRAC = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3*DIR_W-1:0]   ray_orig_in,
   input  logic [3*DIR_W-1:0]   ray_dir_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3*DIR_W-1:0]   ray_orig_out,
   output logic [3*OUT_W-1:0]   inv_ray_dir,
   output logic [2:0]           div_by_zero
);

   localparam int CNT_W = $clog2(OUT_W);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OUT_W - 1);
   // The dividend N = 2^(DIR_FRAC+OUT_FRAC) has a single 1 bit; it enters on this step.
   localparam logic [CNT_W-1:0] ONE_POS  = CNT_W'(DIR_FRAC + OUT_FRAC);
   localparam logic [OUT_W-1:0] Q_MAX    = {1'b0, {(OUT_W-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

   state_t             r_state, w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_sign, r_zero, r_dbz;
   logic [DIR_W-1:0]   r_mag [3];
   logic [DIR_W-1:0]   r_rem [3];
   logic [OUT_W-1:0]   r_quo [3];
   logic [3*DIR_W-1:0] r_orig;
   logic [3*OUT_W-1:0] r_inv;

   logic [DIR_W-1:0]   w_dir      [3];
   logic [DIR_W-1:0]   w_dir_mag  [3];
   logic [DIR_W:0]     w_trial    [3];
   logic [DIR_W-1:0]   w_rem_next [3];
   logic [OUT_W-1:0]   w_quo_next [3];
   logic [OUT_W-1:0]   w_sat      [3];
   logic [OUT_W-1:0]   w_inv      [3];
   logic               w_accept, w_last;

   assign in_ready     = (r_state == IDLE);
   assign out_valid    = (r_state == DONE);
   assign w_accept     = in_valid && in_ready;
   assign w_last       = (r_state == DIVIDE) && (r_cnt == '0);
   assign ray_orig_out = r_orig;
   assign inv_ray_dir  = r_inv;
   assign div_by_zero  = r_dbz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)     w_state_next = DIVIDE;
         DIVIDE:  if (r_cnt == '0)  w_state_next = DONE;
         DONE:    if (out_ready)    w_state_next = IDLE;
         default:                   w_state_next = IDLE;
      endcase
   end

   always_comb begin
      for (int a = 0; a < 3; a++) begin
         w_dir[a]     = ray_dir_in[a*DIR_W +: DIR_W];
         // Unsigned magnitude keeps -2^(DIR_W-1) exact.
         w_dir_mag[a] = w_dir[a][DIR_W-1] ? -w_dir[a] : w_dir[a];
         w_trial[a]   = {r_rem[a], (r_cnt == ONE_POS)};
         if (w_trial[a] >= {1'b0, r_mag[a]}) begin
            w_rem_next[a] = DIR_W'(w_trial[a] - {1'b0, r_mag[a]});
            w_quo_next[a] = {r_quo[a][OUT_W-2:0], 1'b1};
         end else begin
            w_rem_next[a] = w_trial[a][DIR_W-1:0];
            w_quo_next[a] = {r_quo[a][OUT_W-2:0], 1'b0};
         end
         w_sat[a] = w_quo_next[a][OUT_W-1] ? Q_MAX : w_quo_next[a];
         w_inv[a] = r_zero[a] ? '0 : (r_sign[a] ? -w_sat[a] : w_sat[a]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_sign <= '0;
         r_zero <= '0;
         r_dbz  <= '0;
         r_orig <= '0;
         r_inv  <= '0;
         for (int a = 0; a < 3; a++) begin
            r_mag[a] <= '0;
            r_rem[a] <= '0;
            r_quo[a] <= '0;
         end
      end else if (w_accept) begin
         r_orig <= ray_orig_in;
         r_cnt  <= CNT_INIT;
         for (int a = 0; a < 3; a++) begin
            r_sign[a] <= w_dir[a][DIR_W-1];
            r_zero[a] <= (w_dir[a] == '0);
            r_mag[a]  <= w_dir_mag[a];
            r_rem[a]  <= '0;
            r_quo[a]  <= '0;
         end
      end else if (r_state == DIVIDE) begin
         r_cnt <= r_cnt - CNT_W'(1);
         for (int a = 0; a < 3; a++) begin
            r_rem[a] <= w_rem_next[a];
            r_quo[a] <= w_quo_next[a];
         end
         if (w_last) begin
            r_dbz <= r_zero;
            for (int a = 0; a < 3; a++) r_inv[a*OUT_W +: OUT_W] <= w_inv[a];
         end
      end
   end

endmodule

// File: tb/tb_ray_inv_dir_setup.sv
// Bench for ray_inv_dir_setup: directed spec vectors, handshake timing, back-pressure,
// mid-divide reset and randomized rays against an integer-arithmetic reciprocal model.
module tb_ray_inv_dir_setup;

   localparam int DW = 28;
   localparam int OW = 36;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [3*DW-1:0] ray_orig_in;
   logic [3*DW-1:0] ray_dir_in;
   logic            out_valid;
   logic            out_ready;
   logic [3*DW-1:0] ray_orig_out;
   logic [3*OW-1:0] inv_ray_dir;
   logic [2:0]      div_by_zero;

   int n_vec = 0;
   int n_miss = 0;

   ray_inv_dir_setup dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ray_orig_in  (ray_orig_in),
      .ray_dir_in   (ray_dir_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .ray_orig_out (ray_orig_out),
      .inv_ray_dir  (inv_ray_dir),
      .div_by_zero  (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: inv = trunc(2^32 / d) with sign, saturated, zero axis -> 0 + flag.
   function automatic void model(input logic [3*DW-1:0] d,
                                 output logic [3*OW-1:0] inv, output logic [2:0] dbz);
      longint v, mag, q, r;
      inv = '0;
      dbz = '0;
      for (int a = 0; a < 3; a++) begin
         v   = longint'($signed(d[a*DW +: DW]));
         mag = (v < 0) ? -v : v;
         if (mag == 0) begin
            dbz[a] = 1'b1;
         end else begin
            q = (longint'(1) <<< 32) / mag;
            if (q > (longint'(1) <<< 35) - 1) q = (longint'(1) <<< 35) - 1;
            r = (v < 0) ? -q : q;
            inv[a*OW +: OW] = OW'(r);
         end
      end
   endfunction

   function automatic logic [DW-1:0] rand_comp();
      logic [DW-1:0] x;
      case ($urandom_range(0, 7))
         0:       x = '0;
         1:       x = DW'(1);
         2:       x = '1;
         3:       x = {1'b1, {(DW-1){1'b0}}};
         4:       x = {1'b0, {(DW-1){1'b1}}};
         default: begin
            x = DW'($urandom) >> $urandom_range(0, DW-1);
            if ($urandom_range(0, 1) == 1) x = -x;
         end
      endcase
      return x;
   endfunction

   function automatic logic [3*DW-1:0] rand_ray();
      return {rand_comp(), rand_comp(), rand_comp()};
   endfunction

   task automatic send_ray(input logic [3*DW-1:0] o, input logic [3*DW-1:0] d, output bit ok);
      int n = 0;
      ray_orig_in = o;
      ray_dir_in  = d;
      in_valid    = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = in_ready;
      if (!ok) begin
         n_vec++;
         n_miss++;
         $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wait_out(output bit ok);
      int n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = out_valid;
      if (!ok) begin
         n_vec++;
         n_miss++;
         $display("FAIL result_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
      end
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      ray_orig_in = '0;
      ray_dir_in = '0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, ray_orig_out, inv_ray_dir, div_by_zero} !== {1'b1, {(1+3*DW+3*OW+3){1'b0}}}) begin
         n_miss++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b orig=%h inv=%h dbz=%b, required 1 0 0 0 0",
                  in_ready, out_valid, ray_orig_out, inv_ray_dir, div_by_zero);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [3*DW-1:0] dirs [3];
      logic [3*OW-1:0] invs [3];
      logic [2:0]      dbzs [3];
      logic [3*DW-1:0] o;
      bit ok;
      dirs[0] = {28'h000C000, 28'hFFF8000, 28'h0004000};
      invs[0] = {36'h0_0001_5555, 36'hF_FFFE_0000, 36'h0_0004_0000};
      dbzs[0] = 3'b000;
      dirs[1] = {28'h0004000, 28'h0000000, 28'h0004000};
      invs[1] = {36'h0_0004_0000, 36'h0_0000_0000, 36'h0_0004_0000};
      dbzs[1] = 3'b010;
      dirs[2] = {28'hFFFFFFF, 28'h8000000, 28'h0000001};
      invs[2] = {36'hF_0000_0000, 36'hF_FFFF_FFE0, 36'h1_0000_0000};
      dbzs[2] = 3'b000;
      for (int i = 0; i < 3; i++) begin
         o = {28'(i + 7), 28'h1234567, 28'hABCDEF0};
         send_ray(o, dirs[i], ok);
         if (ok) wait_out(ok);
         if (ok) begin
            n_vec++;
            if ({ray_orig_out, inv_ray_dir, div_by_zero} !== {o, invs[i], dbzs[i]}) begin
               n_miss++;
               $display("FAIL directed[%0d]: inv=%h dbz=%b orig=%h, required inv=%h dbz=%b orig=%h",
                        i, inv_ray_dir, div_by_zero, ray_orig_out, invs[i], dbzs[i], o);
            end
            take_out();
         end
      end
   endtask

   // Accept edge = edge 0; sample i is taken just after edge i.
   task automatic test_latency();
      int first_ov = -1, first_ir = -1, ov_cnt = 0;
      out_ready   = 1'b1;
      ray_orig_in = '0;
      ray_dir_in  = {28'h0004000, 28'h0004000, 28'h0004000};
      in_valid    = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ov_cnt++;
            if (first_ov < 0) first_ov = i;
         end
         if (in_ready && first_ir < 0) first_ir = i;
      end
      out_ready = 1'b0;
      n_vec++;
      if (first_ov != 36) begin
         n_miss++;
         $display("FAIL latency_out_valid: first high after edge %0d, required 36", first_ov);
      end
      n_vec++;
      if (ov_cnt != 1) begin
         n_miss++;
         $display("FAIL latency_out_width: out_valid high %0d cycles, required 1", ov_cnt);
      end
      n_vec++;
      if (first_ir != 37) begin
         n_miss++;
         $display("FAIL latency_in_ready: high again after edge %0d, required 37", first_ir);
      end
   endtask

   task automatic test_backpressure();
      logic [3*DW-1:0] o, d;
      logic [3*OW-1:0] e_inv;
      logic [2:0]      e_dbz;
      bit ok;
      o = {28'h0111111, 28'h0222222, 28'h0333333};
      d = {28'hFFFC000, 28'h0001000, 28'h0000003};
      model(d, e_inv, e_dbz);
      send_ray(o, d, ok);
      if (ok) wait_out(ok);
      if (!ok) return;
      ray_orig_in = '1;
      ray_dir_in  = {28'h0004000, 28'h0004000, 28'h0004000};
      in_valid    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if ({out_valid, in_ready, ray_orig_out, inv_ray_dir, div_by_zero} !== {2'b10, o, e_inv, e_dbz}) begin
            n_miss++;
            $display("FAIL hold[%0d]: ov=%b ir=%b inv=%h dbz=%b orig=%h, required ov=1 ir=0 inv=%h dbz=%b orig=%h",
                     i, out_valid, in_ready, inv_ray_dir, div_by_zero, ray_orig_out, e_inv, e_dbz, o);
         end
         @(negedge clk);
      end
      #1 in_valid = 1'b0;
      take_out();
      n_vec++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_miss++;
         $display("FAIL hold_no_accept: ir=%b ov=%b after release, required ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_divide();
      logic [3*DW-1:0] o, d;
      logic [3*OW-1:0] e_inv;
      logic [2:0]      e_dbz;
      bit ok;
      send_ray({28'h0AAAAAA, 28'h0555555, 28'h0123456}, {28'h0002000, 28'hFFFF000, 28'h0000800}, ok);
      if (!ok) return;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({in_ready, out_valid, ray_orig_out, inv_ray_dir, div_by_zero} !== {1'b1, {(1+3*DW+3*OW+3){1'b0}}}) begin
         n_miss++;
         $display("FAIL reset_mid_divide: ir=%b ov=%b orig=%h inv=%h dbz=%b, required 1 0 0 0 0",
                  in_ready, out_valid, ray_orig_out, inv_ray_dir, div_by_zero);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL reset_discard: out_valid=%b, required 0", out_valid);
      end
      o = {28'h0FEDCBA, 28'h0000001, 28'h0765432};
      d = {28'h0000000, 28'hFFFE000, 28'h0006000};
      model(d, e_inv, e_dbz);
      send_ray(o, d, ok);
      if (ok) wait_out(ok);
      if (ok) begin
         n_vec++;
         if ({ray_orig_out, inv_ray_dir, div_by_zero} !== {o, e_inv, e_dbz}) begin
            n_miss++;
            $display("FAIL after_reset: inv=%h dbz=%b orig=%h, required inv=%h dbz=%b orig=%h",
                     inv_ray_dir, div_by_zero, ray_orig_out, e_inv, e_dbz, o);
         end
         take_out();
      end
   endtask

   task automatic test_random();
      logic [3*DW-1:0] o, d;
      logic [3*OW-1:0] e_inv;
      logic [2:0]      e_dbz;
      bit ok;
      for (int i = 0; i < 40; i++) begin
         o = {DW'($urandom), DW'($urandom), DW'($urandom)};
         d = rand_ray();
         model(d, e_inv, e_dbz);
         send_ray(o, d, ok);
         if (ok) wait_out(ok);
         if (!ok) break;
         n_vec++;
         if ({ray_orig_out, inv_ray_dir, div_by_zero} !== {o, e_inv, e_dbz}) begin
            n_miss++;
            $display("FAIL random[%0d]: dir=%h inv=%h dbz=%b orig=%h, required inv=%h dbz=%b orig=%h",
                     i, d, inv_ray_dir, div_by_zero, ray_orig_out, e_inv, e_dbz, o);
         end
         take_out();
      end
   endtask

   // in_valid held high and out_ready tied high: one ray every OUT_W+2 cycles.
   task automatic test_back_to_back();
      logic [3*OW+3-1:0] exp_q [$];
      int acc_cyc [$];
      logic [3*OW-1:0] e_inv;
      logic [2:0]      e_dbz;
      logic [3*OW+3-1:0] e;
      int sent = 0, got = 0;
      bit accepted;
      out_ready   = 1'b1;
      ray_orig_in = '0;
      ray_dir_in  = rand_ray();
      in_valid    = 1'b1;
      for (int c = 0; c < 300 && got < 3; c++) begin
         accepted = 1'b0;
         if (out_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            got++;
            n_vec++;
            if ({inv_ray_dir, div_by_zero} !== e) begin
               n_miss++;
               $display("FAIL b2b_result[%0d]: inv=%h dbz=%b, required inv=%h dbz=%b",
                        got, inv_ray_dir, div_by_zero, e[3*OW+2:3], e[2:0]);
            end
         end
         if (in_valid && in_ready) begin
            model(ray_dir_in, e_inv, e_dbz);
            exp_q.push_back({e_inv, e_dbz});
            acc_cyc.push_back(c);
            sent++;
            accepted = 1'b1;
         end
         @(posedge clk);
         #1;
         if (accepted) begin
            if (sent < 3) ray_dir_in = rand_ray();
            else          in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_vec++;
      if (got != 3 || acc_cyc.size() != 3) begin
         n_miss++;
         $display("FAIL b2b_count: results=%0d accepts=%0d, required 3 3", got, acc_cyc.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_vec++;
            if (acc_cyc[i] - acc_cyc[i-1] != OW + 2) begin
               n_miss++;
               $display("FAIL b2b_spacing[%0d]: %0d cycles, required %0d", i, acc_cyc[i] - acc_cyc[i-1], OW + 2);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_latency();
      test_backpressure();
      test_reset_mid_divide();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
